// File: rtl/block_put_if.sv
// block_put_if: tile command, status and single-port memory signals for block_put
interface block_put_if #(
  parameter int DATA_W = 16,
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int ADDR_W = 10
);
  logic                    start;
  logic [9:0]              start_row;
  logic [9:0]              start_col;
  logic [9:0]              num_cols;
  logic [9:0]              matrix_len;
  logic                    accumulate;
  logic [J*K*DATA_W-1:0]   block;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;
  logic                    done;
  modport master (
    output start, start_row, start_col, num_cols, matrix_len, accumulate, block, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );
  modport slave (
    input  start, start_row, start_col, num_cols, matrix_len, accumulate, block, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );
endinterface

// File: rtl/block_put.sv
// block_put: scatters a JxK tile into a row-major matrix memory with clipping and optional accumulate
module block_put #(
  parameter int DATA_W = 16,
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int ADDR_W = 10
) (
  input logic       clk,
  input logic       rst,
  block_put_if.slave bus
);
  localparam int IW = $clog2(J + 1);
  localparam int JW = $clog2(K + 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t                state_q, state_d;
  logic [9:0]            row_q, row_d, col_q, col_d, nc_q, nc_d, len_q, len_d;
  logic                  acc_q, acc_d;
  logic [J*K*DATA_W-1:0] blk_q, blk_d;
  logic [IW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic                  inb, last, re, we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     elem;
  // r < len/nc is evaluated as (r+1)*nc <= len, which needs no divider
  function automatic logic in_bounds(input logic [9:0] row, col, nc, len, input int i, input int j);
    logic [11:0] r, c;
    r = 12'(row) + 12'(i);
    c = 12'(col) + 12'(j);
    return (nc != 10'd0) && (c < 12'(nc)) && ((23'(r + 12'd1) * 23'(nc)) <= 23'(len));
  endfunction
  function automatic logic [ADDR_W-1:0] addr_of(input logic [9:0] row, col, nc, input int i, input int j);
    logic [11:0] r, c;
    r = 12'(row) + 12'(i);
    c = 12'(col) + 12'(j);
    return ADDR_W'(24'(r) * 24'(nc) + 24'(c));
  endfunction
  always_comb begin
    inb     = in_bounds(row_q, col_q, nc_q, len_q, int'(i_q), int'(j_q));
    addr    = addr_of(row_q, col_q, nc_q, int'(i_q), int'(j_q));
    elem    = blk_q[(int'(i_q) * K + int'(j_q)) * DATA_W +: DATA_W];
    last    = (i_q == IW'(J - 1)) && (j_q == JW'(K - 1));
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    nc_d    = nc_q;
    len_d   = len_q;
    acc_d   = acc_q;
    blk_d   = blk_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: if (bus.start) begin
        row_d   = bus.start_row;
        col_d   = bus.start_col;
        nc_d    = bus.num_cols;
        len_d   = bus.matrix_len;
        acc_d   = bus.accumulate;
        blk_d   = bus.block;
        i_d     = '0;
        j_d     = '0;
        state_d = (bus.accumulate && in_bounds(bus.start_row, bus.start_col, bus.num_cols,
                                               bus.matrix_len, 0, 0)) ? RD : WR;
      end
      RD: state_d = WR;
      WR: if (last) begin
        state_d = DONE;
        i_d     = '0;
        j_d     = '0;
      end else begin
        j_d     = (j_q == JW'(K - 1)) ? '0 : j_q + 1'b1;
        i_d     = (j_q == JW'(K - 1)) ? i_q + 1'b1 : i_q;
        state_d = (acc_q && in_bounds(row_q, col_q, nc_q, len_q, int'(i_d), int'(j_d))) ? RD : WR;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs decode straight from the async-reset state so strobes drop the moment rst rises
  assign re            = state_q == RD;
  assign we            = (state_q == WR) && inb;
  assign bus.mem_re    = re;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = (re || we) ? addr : '0;
  assign bus.mem_wdata = we ? (acc_q ? bus.mem_rdata + elem : elem) : '0;
  assign bus.busy      = re || (state_q == WR);
  assign bus.done      = state_q == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      nc_q    <= '0;
      len_q   <= '0;
      acc_q   <= 1'b0;
      blk_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      nc_q    <= nc_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      blk_q   <= blk_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end
endmodule
